sel_pipe_mux: RTL and testbench

Parametrised N-to-1 operand selector with a registered, flow-controlled output stage for the pipelined datapath. It generalises the combinational 3-to-1 select to NUM inputs of SIZE bits. The selected word is captured into a valid/ready output register backed by a one-entry skid buffer, so the stage can sit between pipeline registers and absorb a downstream stall without losing a word. A flush input discards in-flight words, for use on branch and hazard flushes.

---
 rtl/sel_pipe_mux.sv | 95 +++++++++
 tb/tb_sel_pipe_mux.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sel_pipe_mux.sv
// sel_pipe_mux: NUM-to-1 operand selector feeding a registered valid/ready
// output stage with a one-entry skid buffer. Holds at most two words; flush
// drops both and refuses the word offered in the same cycle.
module sel_pipe_mux #(
  parameter int SIZE  = 32,
  parameter int NUM   = 3,
  parameter int SEL_W = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [NUM*SIZE-1:0] data_i,
  input  logic [SEL_W-1:0]    select_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [SIZE-1:0]     data_o,
  output logic [SEL_W-1:0]    sel_o
);

  logic              r_out_valid;
  logic [SIZE-1:0]   r_out_data;
  logic [SEL_W-1:0]  r_out_sel;
  logic              r_skid_valid;
  logic [SIZE-1:0]   r_skid_data;
  logic [SEL_W-1:0]  r_skid_sel;

  logic [SIZE-1:0]   w_word;
  logic              w_accept;
  logic              w_consume;

  // Select the addressed input; any index past the last input falls back to the last one.
  always_comb begin
    w_word = data_i[(NUM-1)*SIZE +: SIZE];
    for (int k = 0; k < NUM-1; k++) begin
      if (select_i == SEL_W'(k)) begin
        w_word = data_i[k*SIZE +: SIZE];
      end
    end
  end

  // Handshake decode. ready_o comes straight from the skid flag, so it never
  // depends on ready_i within the same cycle.
  always_comb begin
    ready_o   = !r_skid_valid;
    w_accept  = valid_i && !r_skid_valid && !flush_i;
    w_consume = r_out_valid && ready_i;
  end

  // Output/skid register update: refill OUT from SKID first so order stays FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_sel    <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_sel   <= '0;
    end else if (flush_i) begin
      // Payload registers keep their contents; only the valid flags drop.
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_out_valid || w_consume) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= r_skid_data;
        r_out_sel    <= r_skid_sel;
        r_skid_valid <= w_accept;
        if (w_accept) begin
          r_skid_data <= w_word;
          r_skid_sel  <= select_i;
        end
      end else begin
        r_out_valid <= w_accept;
        if (w_accept) begin
          r_out_data <= w_word;
          r_out_sel  <= select_i;
        end
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= w_word;
      r_skid_sel   <= select_i;
    end
  end

  // Registered outputs.
  always_comb begin
    valid_o = r_out_valid;
    data_o  = r_out_data;
    sel_o   = r_out_sel;
  end

endmodule

// File: tb/tb_sel_pipe_mux.sv
// tb_sel_pipe_mux: directed checks on a NUM=3/SIZE=32 instance and a random
// handshake run on a NUM=5/SIZE=8 instance against a two-entry FIFO model.
module tb_sel_pipe_mux;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Instance A: default parameters
  logic        a_rst, a_flush, a_valid, a_ready_o, a_valid_o, a_rdy;
  logic [95:0] a_data;
  logic [1:0]  a_sel, a_sel_o;
  logic [31:0] a_data_o;

  sel_pipe_mux u_dut_a (
    .clk_i(clk), .rst_i(a_rst), .flush_i(a_flush), .valid_i(a_valid),
    .ready_o(a_ready_o), .data_i(a_data), .select_i(a_sel),
    .valid_o(a_valid_o), .ready_i(a_rdy), .data_o(a_data_o), .sel_o(a_sel_o)
  );

  // Instance B: NUM=5, SIZE=8
  logic        b_rst, b_flush, b_valid, b_ready_o, b_valid_o, b_rdy;
  logic [39:0] b_data;
  logic [2:0]  b_sel, b_sel_o;
  logic [7:0]  b_data_o;

  sel_pipe_mux #(.SIZE(8), .NUM(5), .SEL_W(3)) u_dut_b (
    .clk_i(clk), .rst_i(b_rst), .flush_i(b_flush), .valid_i(b_valid),
    .ready_o(b_ready_o), .data_i(b_data), .select_i(b_sel),
    .valid_o(b_valid_o), .ready_i(b_rdy), .data_o(b_data_o), .sel_o(b_sel_o)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] w_arr [4];
  logic [31:0] x1, x2;

  // model state for instance B: queue entries are {sel, data}
  logic [10:0] mq[$];
  logic [7:0]  m_last_d;
  logic [2:0]  m_last_s;

  function automatic logic [7:0] pick_b(input logic [39:0] d, input logic [2:0] s);
    logic [7:0] ins [5];
    for (int k = 0; k < 5; k++) ins[k] = d[k*8 +: 8];
    if (s < 3'd5) return ins[s];
    return ins[4];
  endfunction

  initial begin
    a_rst = 1; a_flush = 0; a_valid = 0; a_rdy = 0; a_data = '0; a_sel = '0;
    b_rst = 1; b_flush = 0; b_valid = 0; b_rdy = 0; b_data = '0; b_sel = '0;

    // reset and basic select
    cyc(); cyc();
    check_val("rst_valid", a_valid_o, 0);
    check_val("rst_data",  a_data_o, 0);
    check_val("rst_sel",   a_sel_o, 0);
    check_val("rst_ready", a_ready_o, 1);
    a_rst = 0;
    a_data = {32'hC, 32'hB, 32'hA}; a_sel = 2'd1; a_valid = 1; a_rdy = 1;
    cyc();
    check_val("basic_data",  a_data_o, 32'hB);
    check_val("basic_sel",   a_sel_o, 1);
    check_val("basic_valid", a_valid_o, 1);

    // out-of-range select
    a_data = {32'd3, 32'd2, 32'd1}; a_sel = 2'd3;
    cyc();
    check_val("oor_data",  a_data_o, 3);
    check_val("oor_sel",   a_sel_o, 3);
    check_val("oor_valid", a_valid_o, 1);
    a_sel = 2'd0;
    cyc();
    check_val("sel0_data", a_data_o, 1);
    a_valid = 0;
    cyc();
    check_val("drain_valid", a_valid_o, 0);

    // stall with skid
    for (int i = 0; i < 4; i++) w_arr[i] = 32'h1000_0100 + 32'(i);
    a_rdy = 0; a_sel = 2'd0;
    a_data = {64'd0, w_arr[0]}; a_valid = 1;
    check_val("stall_rdy0", a_ready_o, 1);
    cyc();
    check_val("stall_w0_valid", a_valid_o, 1);
    check_val("stall_w0_data", a_data_o, w_arr[0]);
    a_data = {64'd0, w_arr[1]};
    check_val("stall_rdy1", a_ready_o, 1);
    cyc();
    check_val("stall_hold_w0", a_data_o, w_arr[0]);
    check_val("stall_rdy_drop", a_ready_o, 0);
    a_data = {64'd0, w_arr[2]};
    for (int i = 0; i < 2; i++) begin
      cyc();
      check_val("stall_hold_data", a_data_o, w_arr[0]);
      check_val("stall_hold_sel", a_sel_o, 0);
      check_val("stall_refuse", a_ready_o, 0);
    end
    begin
      int idx = 2;
      logic acc;
      a_rdy = 1;
      for (int k = 0; k < 4; k++) begin
        check_val("rel_valid", a_valid_o, 1);
        check_val("rel_data", a_data_o, w_arr[k]);
        a_valid = (idx < 4);
        a_data = {64'd0, w_arr[idx < 4 ? idx : 3]};
        acc = a_valid && a_ready_o;
        cyc();
        if (acc) idx++;
      end
      check_val("rel_all_taken", idx, 4);
    end
    a_valid = 0;
    check_val("rel_empty", a_valid_o, 0);

    // full throughput
    for (int i = 0; i < 16; i++) begin
      a_valid = 1; a_sel = 2'(i % 3);
      a_data = {32'h3000_0000 + 32'(i), 32'h2000_0000 + 32'(i), 32'h1000_0000 + 32'(i)};
      check_val("tp_ready_pre", a_ready_o, 1);
      cyc();
      check_val("tp_valid", a_valid_o, 1);
      check_val("tp_data", a_data_o, 32'h1000_0000 * (i % 3 + 1) + 32'(i));
      check_val("tp_ready_post", a_ready_o, 1);
    end

    // reset mid-transfer
    a_valid = 0; a_rst = 1;
    cyc();
    a_rst = 0;
    check_val("mrst_valid", a_valid_o, 0);
    check_val("mrst_data", a_data_o, 0);
    check_val("mrst_ready", a_ready_o, 1);

    // flush with OUT and SKID full
    x1 = 32'hAAAA_0001; x2 = 32'hAAAA_0002;
    a_rdy = 0; a_sel = 2'd0; a_valid = 1;
    a_data = {64'd0, x1};
    cyc();
    a_data = {64'd0, x2};
    cyc();
    check_val("fl_full_ready", a_ready_o, 0);
    check_val("fl_full_valid", a_valid_o, 1);
    a_flush = 1; a_data = {64'd0, 32'h55};
    cyc();
    a_flush = 0; a_valid = 0;
    check_val("fl_valid", a_valid_o, 0);
    check_val("fl_ready", a_ready_o, 1);
    check_val("fl_data_kept", a_data_o, x1);
    a_rdy = 1;
    cyc(); cyc();
    check_val("fl_no55_valid", a_valid_o, 0);
    check_val("fl_no55_data", a_data_o, x1);
    a_rst = 1;

    // random handshake on instance B
    cyc(); cyc();
    b_rst = 0;
    mq.delete(); m_last_d = '0; m_last_s = '0;
    for (int c = 0; c < 10000; c++) begin
      logic [7:0] e_d;
      logic [2:0] e_s;
      logic       stalled, m_ready, m_acc, m_cons;
      logic [7:0] held_d;
      logic [2:0] held_s;
      if (mq.size() > 0) begin
        e_d = mq[0][7:0]; e_s = mq[0][10:8];
      end else begin
        e_d = m_last_d; e_s = m_last_s;
      end
      check_val("rnd_valid", b_valid_o, mq.size() > 0);
      check_val("rnd_ready", b_ready_o, mq.size() < 2);
      check_val("rnd_data", b_data_o, e_d);
      check_val("rnd_sel", b_sel_o, e_s);

      b_rst   = ($urandom_range(0, 999) == 0);
      b_flush = ($urandom_range(0, 39) == 0);
      b_valid = ($urandom_range(0, 3) != 0);
      b_rdy   = ($urandom_range(0, 2) != 0);
      b_data  = {$urandom(), $urandom()} ;
      b_sel   = 3'($urandom_range(0, 7));

      stalled = b_valid_o && !b_rdy && !b_flush && !b_rst;
      held_d = b_data_o; held_s = b_sel_o;

      m_ready = (mq.size() < 2);
      m_acc   = b_valid && m_ready && !b_flush;
      m_cons  = (mq.size() > 0) && b_rdy;
      if (b_rst) begin
        mq.delete(); m_last_d = '0; m_last_s = '0;
      end else if (b_flush) begin
        mq.delete();
      end else begin
        if (m_cons) void'(mq.pop_front());
        if (m_acc) mq.push_back({b_sel, pick_b(b_data, b_sel)});
      end
      if (mq.size() > 0) begin
        m_last_d = mq[0][7:0]; m_last_s = mq[0][10:8];
      end

      cyc();
      if (stalled) begin
        check_val("rnd_stall_data", b_data_o, held_d);
        check_val("rnd_stall_sel", b_sel_o, held_s);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
